// File: rtl/monster_sprite_fetch.sv
// Address stage for the animated monster sprite RAM: per-pixel slot hit test, RAM address
// generation, and re-alignment of the RAM's 1-cycle read data into a chroma-keyed pixel.
`timescale 1ns/1ps
module monster_sprite_fetch #(
    parameter int          N_SLOTS   = 4,
    parameter int          SPRITE_W  = 45,
    parameter int          SPRITE_H  = 45,
    parameter logic [23:0] KEY_COLOR = 24'hFFFFFF,
    localparam int         SW        = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic          pix_valid,
    input  logic          frame_start,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_slot,
    input  logic [9:0]    wr_x,
    input  logic [9:0]    wr_y,
    input  logic          wr_active,
    output logic [18:0]   read_address,
    input  logic [23:0]   ram_data,
    output logic          pix_out_valid,
    output logic          pix_out_hit,
    output logic [SW-1:0] pix_out_slot,
    output logic [23:0]   pix_out_rgb
);

    localparam logic [18:0] OOR_ADDR = 19'(SPRITE_W * SPRITE_H);

    logic [9:0]    r_sh_x   [N_SLOTS];
    logic [9:0]    r_sh_y   [N_SLOTS];
    logic          r_sh_act [N_SLOTS];
    logic [9:0]    r_ac_x   [N_SLOTS];
    logic [9:0]    r_ac_y   [N_SLOTS];
    logic          r_ac_act [N_SLOTS];

    logic [10:0]   w_dx       [N_SLOTS];
    logic [10:0]   w_dy       [N_SLOTS];
    logic          w_slot_hit [N_SLOTS];

    logic          w_hit;
    logic [SW-1:0] w_win;
    logic [10:0]   w_sel_dx;
    logic [10:0]   w_sel_dy;
    logic [18:0]   w_addr;

    logic [18:0]   r_read_address;
    logic          r_s1_valid;
    logic          r_s1_hit;
    logic [SW-1:0] r_s1_slot;
    logic          r_s2_valid;
    logic          r_s2_hit;
    logic [SW-1:0] r_s2_slot;
    logic          r_out_valid;
    logic          r_out_hit;
    logic [SW-1:0] r_out_slot;
    logic [23:0]   r_out_rgb;
    logic          w_out_hit;

    // A write coinciding with frame_start must reach the active copy too, so the
    // commit takes the incoming value rather than the stale shadow entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                r_sh_x[i]   <= '0;
                r_sh_y[i]   <= '0;
                r_sh_act[i] <= 1'b0;
                r_ac_x[i]   <= '0;
                r_ac_y[i]   <= '0;
                r_ac_act[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                if (wr_en && (wr_slot == SW'(i))) begin
                    r_sh_x[i]   <= wr_x;
                    r_sh_y[i]   <= wr_y;
                    r_sh_act[i] <= wr_active;
                end
                if (frame_start) begin
                    if (wr_en && (wr_slot == SW'(i))) begin
                        r_ac_x[i]   <= wr_x;
                        r_ac_y[i]   <= wr_y;
                        r_ac_act[i] <= wr_active;
                    end else begin
                        r_ac_x[i]   <= r_sh_x[i];
                        r_ac_y[i]   <= r_sh_y[i];
                        r_ac_act[i] <= r_sh_act[i];
                    end
                end
            end
        end
    end

    // The 11-bit difference's MSB is the borrow, i.e. DrawX < x; this stops right-edge wrap.
    always_comb begin
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            w_dx[i]       = {1'b0, DrawX} - {1'b0, r_ac_x[i]};
            w_dy[i]       = {1'b0, DrawY} - {1'b0, r_ac_y[i]};
            w_slot_hit[i] = r_ac_act[i] && !w_dx[i][10] && !w_dy[i][10] &&
                            (w_dx[i] < 11'(SPRITE_W)) && (w_dy[i] < 11'(SPRITE_H));
        end
    end

    always_comb begin
        w_hit    = 1'b0;
        w_win    = '0;
        w_sel_dx = '0;
        w_sel_dy = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!w_hit && w_slot_hit[i]) begin
                w_hit    = 1'b1;
                w_win    = SW'(i);
                w_sel_dx = w_dx[i];
                w_sel_dy = w_dy[i];
            end
        end
        w_addr = w_hit ? (19'(w_sel_dy) * 19'(SPRITE_W) + 19'(w_sel_dx)) : OOR_ADDR;
    end

    assign w_out_hit = r_s2_hit && (ram_data != KEY_COLOR);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_read_address <= OOR_ADDR;
            r_s1_valid     <= 1'b0;
            r_s1_hit       <= 1'b0;
            r_s1_slot      <= '0;
            r_s2_valid     <= 1'b0;
            r_s2_hit       <= 1'b0;
            r_s2_slot      <= '0;
            r_out_valid    <= 1'b0;
            r_out_hit      <= 1'b0;
            r_out_slot     <= '0;
            r_out_rgb      <= '0;
        end else begin
            r_read_address <= w_addr;
            r_s1_valid     <= pix_valid;
            r_s1_hit       <= w_hit && pix_valid;
            r_s1_slot      <= w_win;
            r_s2_valid     <= r_s1_valid;
            r_s2_hit       <= r_s1_hit;
            r_s2_slot      <= r_s1_slot;
            r_out_valid    <= r_s2_valid;
            r_out_hit      <= w_out_hit;
            r_out_slot     <= w_out_hit ? r_s2_slot : '0;
            r_out_rgb      <= w_out_hit ? ram_data : '0;
        end
    end

    assign read_address  = r_read_address;
    assign pix_out_valid = r_out_valid;
    assign pix_out_hit   = r_out_hit;
    assign pix_out_slot  = r_out_slot;
    assign pix_out_rgb   = r_out_rgb;

endmodule
